// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester for single-beat client commands; optional ACCESS timeout via APB_MASTER_TIMEOUT_EN
module apb_master #(
  parameter int addrWidth     = 32,
  parameter int dataWidth     = 8,
  parameter int timeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [addrWidth-1:0] req_addr,
  input  logic [dataWidth-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 sel,
  output logic                 enable,
  output logic                 write,
  output logic [addrWidth-1:0] addr,
  output logic [dataWidth-1:0] wdata,
  input  logic [dataWidth-1:0] rdata,
  input  logic                 ready,
  input  logic                 slverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_next;
  logic   accept;
  logic   done;
  logic   timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CntWidth = $clog2(timeoutCycles);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(timeoutCycles - 1);

  logic [CntWidth-1:0] wait_cnt;

  // Count ACCESS cycles spent waiting; cleared while in SETUP so it starts at 0 in ACCESS
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !ready) begin
      wait_cnt <= wait_cnt + CntWidth'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) && (wait_cnt == CntLast);
`else
  localparam int unused_timeout_cycles = timeoutCycles;

  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, fixed one-cycle SETUP, ACCESS until ready (or timeout)
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (ready || timeout_hit) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign sel       = (state != IDLE);
  assign enable    = (state == ACCESS);

  // Command capture on accept and response capture on completion; ready wins over timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (accept) begin
        write <= req_write;
        addr  <= req_addr;
        if (req_write) begin
          wdata <= req_wdata;
        end
      end
      if (done) begin
        if (ready) begin
          rsp_rdata <= write ? '0 : rdata;
          rsp_err   <= slverr;
        end else begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master against a transfer-level model
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 16;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          sel;
  logic          enable;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          slverr;

  apb_master #(
    .addrWidth    (AW),
    .dataWidth    (DW),
    .timeoutCycles(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .sel      (sel),
    .enable   (enable),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .slverr   (slverr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected bus/response state, kept at the level of whole transfers
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic client_noise();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = DW'($urandom);
  endtask

  task automatic check_bus(input string tag);
    check({tag, "_addr"}, addr, m_addr);
    check({tag, "_write"}, write, m_write);
    check({tag, "_wdata"}, wdata, m_wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      ready     = 1'($urandom);
      slverr    = 1'($urandom);
      rdata     = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("idle_sel", sel, 0);
      check("idle_enable", enable, 0);
      check("idle_req_ready", req_ready, 1);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_rsp_rdata", rsp_rdata, m_rdata);
      check("idle_rsp_err", rsp_err, m_err);
      check_bus("idle");
    end
  endtask

  // One command from accept to response pulse; starts and ends at a negedge with the DUT in IDLE
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic err, input logic [DW-1:0] rd);
    bit abort;
    int n;
    check("acc_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    ready     = 1'($urandom);
    slverr    = 1'($urandom);
    rdata     = DW'($urandom);
    @(posedge clk);
    m_write = wr;
    m_addr  = a;
    if (wr) m_wdata = d;
    @(negedge clk);
    check("setup_sel", sel, 1);
    check("setup_enable", enable, 0);
    check("setup_req_ready", req_ready, 0);
    check("setup_rsp_valid", rsp_valid, 0);
    check("setup_rsp_rdata", rsp_rdata, m_rdata);
    check("setup_rsp_err", rsp_err, m_err);
    check_bus("setup");
    client_noise();
    ready  = 1'($urandom);
    slverr = 1'($urandom);
    rdata  = DW'($urandom);
    @(posedge clk);
    abort = TimeoutEn && (waits >= TO);
    n = abort ? TO : waits + 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("access_sel", sel, 1);
      check("access_enable", enable, 1);
      check("access_req_ready", req_ready, 0);
      check("access_rsp_valid", rsp_valid, 0);
      check_bus("access");
      client_noise();
      ready  = (i == waits);
      slverr = ready ? err : 1'($urandom);
      rdata  = ready ? rd : DW'($urandom);
      @(posedge clk);
    end
    if (abort) begin
      m_rdata = '0;
      m_err   = 1'b1;
    end else begin
      m_rdata = wr ? '0 : rd;
      m_err   = err;
    end
    @(negedge clk);
    req_valid = 1'b0;
    ready     = 1'($urandom);
    slverr    = 1'($urandom);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, m_rdata);
    check("rsp_err", rsp_err, m_err);
    check("rsp_sel", sel, 0);
    check("rsp_enable", enable, 0);
    check("rsp_req_ready", req_ready, 1);
    check_bus("rsp");
  endtask

  task automatic reset_mid_access();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_00f3;
    req_wdata = 8'h99;
    ready     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_enable", enable, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_sel", sel, 0);
    check("rst_async_enable", enable, 0);
    check("rst_async_req_ready", req_ready, 1);
    check("rst_async_addr", addr, 0);
    check("rst_async_write", write, 0);
    check("rst_async_wdata", wdata, 0);
    check("rst_async_rsp_valid", rsp_valid, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(3);
  endtask

  initial begin
    int waits;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rdata     = '0;
    ready     = 1'b0;
    slverr    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sel", sel, 0);
    check("reset_enable", enable, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    check_bus("reset");
    reset = 1'b1;
    idle(5);

    xfer(1'b1, 32'd1, 8'd25, 0, 1'b0, 8'hc3);
    idle(1);
    xfer(1'b0, 32'd0, 8'h77, 4, 1'b0, 8'h05);
    xfer(1'b0, 32'd2, 8'h00, 0, 1'b1, 8'h3c);
    xfer(1'b0, 32'd2, 8'h00, 0, 1'b0, 8'h11);
    xfer(1'b1, 32'h8000_0001, 8'hff, 1, 1'b1, 8'h22);
    idle(2);
    reset_mid_access();
    xfer(1'b0, 32'd5, 8'h00, 2, 1'b0, 8'h5a);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'd3, 8'h00, 1000, 1'b0, 8'haa);
    xfer(1'b0, 32'd3, 8'h00, TO - 1, 1'b1, 8'h6b);
    xfer(1'b1, 32'd4, 8'h44, TO - 1, 1'b0, 8'h6c);
    xfer(1'b0, 32'd4, 8'h00, TO, 1'b0, 8'h6d);
`endif

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
      xfer(1'($urandom), $urandom, DW'($urandom), waits, 1'($urandom), DW'($urandom));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
